// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory that answers each request after a fixed
// number of wait cycles, reporting misaligned or out-of-range accesses via err.
module mem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic        ready,
   output logic [31:0] rd,
   output logic        err,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t        state;
   logic [3:0]    cnt;
   logic          cap_we;
   logic [31:0]   cap_addr;
   logic [31:0]   cap_wd;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic          legal;
   logic          access;
   assign idx    = cap_addr[AW+1:2];
   assign legal  = cap_addr[1:0] == 2'b00 && cap_addr[31:AW+2] == '0;
   assign access = state == WAIT && cnt == 4'd0;
   // storage has no reset; an aborted write never reaches here because reset forces IDLE
   always_ff @(posedge clk)
      if (access && legal && cap_we) mem[idx] <= cap_wd;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         cap_we   <= 1'b0;
         cap_addr <= 32'h0;
         cap_wd   <= 32'h0;
         ready    <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b0;
         rd       <= 32'h0;
      end else begin
         case (state)
            IDLE: if (req) begin
               state    <= WAIT;
               cnt      <= 4'(LATENCY - 1);
               cap_we   <= we;
               cap_addr <= addr;
               cap_wd   <= wd;
               busy     <= 1'b1;
            end
            WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else begin
               state <= RESP;
               ready <= 1'b1;
               err   <= !legal;
               if (!legal) rd <= 32'h0;
               else if (!cap_we) rd <= mem[idx];
            end
            RESP: begin
               state <= IDLE;
               ready <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized accesses against an array-based reference model,
// plus directed abort, fault and held-request scenarios.
module tb_mem_responder;
   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clk, reset;
   logic        req, we, ready, err, busy;
   logic [31:0] addr, wd, rd;
   logic        req1, we1, ready1, err1, busy1;
   logic [31:0] addr1, wd1, rd1;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] model_rd = 32'h0;

   mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wd(wd),
      .ready(ready), .rd(rd), .err(err), .busy(busy));

   mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wd(wd1),
      .ready(ready1), .rd(rd1), .err(err1), .busy(busy1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic e, output logic [31:0] r);
      e = (a % 4 != 0) || (a / 4 >= DEPTH);
      if (e) model_rd = 32'h0;
      else if (w) model_mem[a / 4] = d;
      else model_rd = model_mem[a / 4];
      r = model_rd;
   endtask

   // the request is driven before its sampling edge; after that edge the inputs are scrambled
   task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d, input string name);
      logic        e_exp;
      logic [31:0] r_exp;
      int          n;
      model(w, a, d, e_exp, r_exp);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wd = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            req = 1'b0; we = ~w; addr = a + 32'd4; wd = ~d;
         end
      end while (!ready && n < 40);
      checks++;
      if (n != LAT + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d edges, expected %0d", name, n, LAT + 1);
      end
      checks++;
      if (err !== e_exp) begin
         errors++;
         $display("FAIL %s err: got %b, expected %b", name, err, e_exp);
      end
      checks++;
      if (rd !== r_exp) begin
         errors++;
         $display("FAIL %s rd: got %h, expected %h", name, rd, r_exp);
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_resp ready/err/busy: got %b%b%b, expected 000", name, ready, err, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wd = 32'h0;
      req1 = 1'b0; we1 = 1'b0; addr1 = 32'h3; wd1 = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rd !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: got ready=%b err=%b busy=%b rd=%h, expected 0 0 0 0", ready, err, busy, rd);
      end
      reset = 1'b1;
   endtask

   task automatic test_init();
      for (int i = 0; i < DEPTH; i++)
         do_access(1'b1, 32'(i * 4), $urandom, "init_write");
   endtask

   task automatic test_write_read();
      do_access(1'b1, 32'h10, 32'hDEADBEEF, "write_10");
      do_access(1'b0, 32'h10, 32'h0, "read_10");
   endtask

   task automatic test_fault();
      do_access(1'b0, 32'h06, 32'h0, "misaligned_read");
      do_access(1'b1, 32'h13, 32'hFFFF_0000, "misaligned_write");
      do_access(1'b0, 32'h100, 32'h0, "range_read");
      do_access(1'b1, 32'hFC, 32'h0BAD_0BAD, "last_word_write");
      do_access(1'b0, 32'h10, 32'h0, "read_10_after_fault");
   endtask

   task automatic test_in_flight();
      do_access(1'b0, 32'h10, 32'h0, "inflight_read_10");
      do_access(1'b0, 32'h14, 32'h0, "inflight_check_14");
   endtask

   task automatic test_abort();
      logic seen;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'h12345678;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || rd !== 32'h0) begin
         errors++;
         $display("FAIL abort_immediate: got ready=%b busy=%b err=%b rd=%h, expected 0 0 0 0", ready, busy, err, rd);
      end
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen |= ready;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_ready: got ready pulse=%b, expected 0", seen);
      end
      reset = 1'b1;
      model_rd = 32'h0;
      do_access(1'b0, 32'h20, 32'h0, "read_20_after_abort");
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int i = 0; i < 40; i++) begin
         a = {$urandom_range(0, DEPTH + 8), 2'b00};
         if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) a[31] = 1'b1;
         do_access(1'($urandom_range(0, 1)), a, $urandom, "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] r, b, e;
      int          last, pulses;
      @(negedge clk);
      req1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         r[i] = ready1; b[i] = busy1; e[i] = err1;
      end
      req1 = 1'b0;
      pulses = 0;
      last = -1;
      for (int i = 0; i < 20; i++) begin
         if (r[i]) begin
            pulses++;
            if (last >= 0) begin
               checks++;
               if (i - last != 3) begin
                  errors++;
                  $display("FAIL b2b_interval: got %0d cycles, expected 3", i - last);
               end
            end
            checks++;
            if (e[i] !== 1'b1) begin
               errors++;
               $display("FAIL b2b_err: got %b, expected 1", e[i]);
            end
            last = i;
         end
         if (!b[i] && i > 0 && i < 19) begin
            checks++;
            if (!b[i-1] || !b[i+1]) begin
               errors++;
               $display("FAIL b2b_idle_gap: got busy %b%b%b around cycle %0d, expected 101", b[i-1], b[i], b[i+1], i);
            end
         end
      end
      checks++;
      if (pulses != 7) begin
         errors++;
         $display("FAIL b2b_pulses: got %0d, expected 7", pulses);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_init();
      test_write_read();
      test_fault();
      test_in_flight();
      test_abort();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
